// File: rtl/br_tag_ctrl.sv
// Branch tag allocator and resolver: hands out one-hot tags, tracks branch
// age dependences, and broadcasts CLEAR/SQUASH outcomes one cycle later.
package br_tag_pkg;
  typedef enum logic [1:0] {
    NOTHING = 2'd0,
    CLEAR   = 2'd1,
    SQUASH  = 2'd2
  } br_task_e;
endpackage

module br_tag_ctrl
  import br_tag_pkg::*;
#(
  parameter int NUM_BR = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc_req,
  output logic              alloc_gnt,
  output logic [NUM_BR-1:0] alloc_b_id,
  output logic [NUM_BR-1:0] cur_b_mask,
  output logic              full,
  input  logic              res_valid,
  input  br_task_e          res_task,
  input  logic [NUM_BR-1:0] res_b_id,
  output br_task_e          rem_br_task,
  output logic [NUM_BR-1:0] rem_b_id
);

  localparam logic [NUM_BR-1:0] ONE = NUM_BR'(1);

  logic [NUM_BR-1:0]             busy_q, busy_d;
  logic [NUM_BR-1:0][NUM_BR-1:0] dep_q, dep_d;
  br_task_e                      rem_task_q, rem_task_d;
  logic [NUM_BR-1:0]             rem_id_q, rem_id_d;

  logic              onehot, accept, clear_acc, squash_acc;
  logic [NUM_BR-1:0] free, low_free, kill, clr;

  assign onehot     = (res_b_id != '0) && ((res_b_id & (res_b_id - ONE)) == '0);
  assign accept     = res_valid && onehot && (res_task == CLEAR || res_task == SQUASH)
                      && ((busy_q & res_b_id) != '0);
  assign clear_acc  = accept && (res_task == CLEAR);
  assign squash_acc = accept && (res_task == SQUASH);
  assign clr        = clear_acc ? res_b_id : '0;

  // Grant works off registered busy, so a tag freed this cycle waits one cycle.
  assign free       = ~busy_q;
  assign low_free   = free & (~free + ONE);
  assign full       = &busy_q;
  assign alloc_gnt  = alloc_req && !full && !squash_acc && !reset;
  assign alloc_b_id = alloc_gnt ? low_free : '0;

  assign cur_b_mask  = busy_q;
  assign rem_br_task = rem_task_q;
  assign rem_b_id    = rem_id_q;

  // Squash victims: the resolving tag plus every branch younger than it.
  always_comb begin
    kill = '0;
    if (squash_acc) begin
      kill = res_b_id;
      for (int i = 0; i < NUM_BR; i++)
        if ((dep_q[i] & res_b_id) != '0) kill[i] = 1'b1;
    end
  end

  always_comb begin
    busy_d = busy_q & ~clr & ~kill;
    dep_d  = dep_q;
    for (int i = 0; i < NUM_BR; i++) begin
      dep_d[i] = dep_q[i] & ~clr;
      if (kill[i]) dep_d[i] = '0;
      if (low_free[i] && alloc_gnt) dep_d[i] = busy_q & ~clr;
    end
    if (alloc_gnt) busy_d = busy_d | low_free;
    rem_task_d = accept ? res_task : NOTHING;
    rem_id_d   = accept ? res_b_id : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q     <= '0;
      dep_q      <= '0;
      rem_task_q <= NOTHING;
      rem_id_q   <= '0;
    end else begin
      busy_q     <= busy_d;
      dep_q      <= dep_d;
      rem_task_q <= rem_task_d;
      rem_id_q   <= rem_id_d;
    end
  end

endmodule

// File: doc/br_tag_ctrl.md
BR_TAG_CTRL -- requirements
Module: br_tag_ctrl

Interface
REQ-001 SHALL have parameter: NUM_BR, default 4, number of branch tags (equals BR_MASK width).
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 SHALL have port: alloc_req  input  1  dispatch requests a tag for one branch this cycle.
REQ-005 SHALL have port: alloc_gnt  output  1  tag granted this cycle (combinational).
REQ-006 SHALL have port: alloc_b_id  output  NUM_BR  one-hot granted tag; zero when alloc_gnt=0.
REQ-007 SHALL have port: cur_b_mask  output  NUM_BR  registered set of outstanding tags, attached by dispatch as b_mask.
REQ-008 SHALL have port: full  output  1  no free tag (all busy bits set).
REQ-009 SHALL have port: res_valid  input  1  branch FU result valid (FU data_ready).
REQ-010 SHALL have port: res_task  input  BR_TASK  FU outcome: CLEAR (predicted correctly) or SQUASH (mispredicted).
REQ-011 SHALL have port: res_b_id  input  NUM_BR  one-hot tag of the resolving branch.
REQ-012 SHALL have port: rem_br_task  output  BR_TASK  registered broadcast task to RS, FUs, ROB.
REQ-013 SHALL have port: rem_b_id  output  NUM_BR  registered broadcast tag; zero when rem_br_task=NOTHING.

Function
REQ-014 SHALL hold state: busy[NUM_BR] and a dependence matrix dep[NUM_BR][NUM_BR], where dep[i][j]=1 means branch i is younger than outstanding branch j.
REQ-015 SHALL drive cur_b_mask=busy and full=(busy all ones).
REQ-016 SHALL grant when alloc_req=1, full=0, and no valid SQUASH is being accepted this cycle; the granted tag is the lowest-index bit of ~busy.
REQ-017 SHALL keep alloc_gnt=0 and alloc_b_id=0 when full=1 or when a SQUASH is accepted; the requester retries without dropping alloc_req.
REQ-018 SHALL, on a grant of tag i, set busy[i] and load dep[i] with busy, excluding any tag being cleared in the same cycle.
REQ-019 SHALL accept a resolution only when res_valid=1, res_b_id is one-hot, res_task is CLEAR or SQUASH, and busy[res_b_id]=1; otherwise it ignores the input and next-cycle rem_br_task=NOTHING.
REQ-020 SHALL, on an accepted CLEAR of tag j, clear busy[j] and clear column j in every dep row.
REQ-021 SHALL, on an accepted SQUASH of tag j, clear busy[j] and busy[i] for every i with dep[i][j]=1, then zero rows j and every such i.
REQ-022 SHALL register broadcasts with 1-cycle latency: after an accepted resolution, rem_br_task=res_task and rem_b_id=res_b_id on the next cycle; otherwise NOTHING and 0.
REQ-023 SHALL make tags freed by CLEAR or SQUASH allocatable from the next cycle only, because grant uses registered busy.
REQ-024 SHALL accept at most one resolution per cycle; a tag never appears in alloc_b_id while it is busy.

Reset
REQ-025 SHALL, while reset=1 (asynchronous assert), force busy=0, dep=0, rem_br_task=NOTHING, rem_b_id=0, giving cur_b_mask=0 and full=0.
REQ-026 SHALL keep alloc_gnt=0 while reset is asserted; operation resumes on the first posedge after deassertion.
REQ-027 SHALL discard any allocation or resolution in flight when reset asserts mid-operation; no broadcast follows.

Verification
REQ-028 SHALL cover fill: alloc_req=1 for 5 cycles with NUM_BR=4 -> grants 0001, 0010, 0100, 1000; full=1 on cycle 5 and alloc_gnt=0 on cycle 5.
REQ-029 SHALL cover CLEAR: tags 0-2 busy, CLEAR res_b_id=0010 -> next cycle rem_br_task=CLEAR, rem_b_id=0010, cur_b_mask=0101, dep[2]=0001.
REQ-030 SHALL cover SQUASH: tags allocated in order 0,1,2, SQUASH tag 0001 -> next cycle rem_br_task=SQUASH, rem_b_id=0001, cur_b_mask=0000.
REQ-031 SHALL cover simultaneous events: full, CLEAR tag 3 with alloc_req=1 -> no grant that cycle; next cycle grant 1000 with dep[3]=0111.
REQ-032 SHALL cover squash vs. alloc: SQUASH tag 1 with alloc_req=1 -> alloc_gnt=0; a stale resolution for a freed tag -> rem_br_task=NOTHING.
REQ-033 SHALL cover reset mid-operation: reset asserted between clock edges with 3 tags busy -> cur_b_mask=0 and rem_br_task=NOTHING immediately, before the next edge.
